// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the instruction fetch unit: default address and
// instruction widths, the HALT opcode, the FSM state type and its encodings.
package fetch_pkg;

  localparam int ADDR_W_DEF  = 12;
  localparam int INSTR_W_DEF = 19;

  // The top nibble of an instruction word holds its opcode.
  localparam logic [3:0] HALT_OPCODE = 4'b1111;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_RUN    = 2'd1;
  localparam state_t ST_HALTED = 2'd2;

  function automatic logic is_halt(input logic [3:0] opcode);
    return opcode == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_ret_stack.sv
// fetch_ret_stack
// Small LIFO of return addresses for the fetch unit. The top of stack is
// always entry 0, so pushes shift entries down and pops shift them up;
// this keeps pop_data a plain register output with no read mux.
// A push while full and a pop while empty are ignored here; the parent
// decides whether that is an error.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (empties the stack)
//   push        write push_data on top (ignored when full)
//   pop         discard the top entry (ignored when empty)
//   push_data   value to push
//   pop_data    current top-of-stack value
//   full        DEPTH entries held
//   empty       no entries held
module fetch_ret_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] count;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && !full) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        mem[i] <= mem[i-1];
      end
      mem[0] <= push_data;
      count  <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem[i] <= mem[i+1];
      end
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage: drives the program counter onto the instruction
// memory address, registers the returned word into a one-entry instruction
// register with valid/ready handshake, handles redirects (branches/jumps),
// and stops fetching after issuing a HALT instruction.
//
// Optional feature, enabled by defining FETCH_RET_STACK_EN: a return-address
// stack. A redirect with call_valid pushes ir_pc+1; ret_valid pops and
// redirects to the popped address. Overflow/underflow sets sticky stack_err.
// Without the macro call_valid/ret_valid are ignored and stack_err is 0.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   fetch_en                     permits IDLE->RUN and new fetches
//   imem_addr / imem_data        instruction memory address (= pc) / read data
//   ir_valid/ir_ready            instruction register handshake to decode
//   ir_data / ir_pc              registered instruction and its address
//   redirect_valid/redirect_addr taken branch/jump and its target
//   call_valid / ret_valid       call (with redirect) / return request
//   halted                       HALT instruction issued, waiting for redirect
//   stack_err                    sticky return-stack overflow/underflow
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter int                INSTR_W     = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                STACK_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [INSTR_W-1:0] ir_data,
  output logic [ADDR_W-1:0]  ir_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  input  logic               call_valid,
  input  logic               ret_valid,
  output logic               halted,
  output logic               stack_err
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              load;
  logic              ret_take;
  logic [ADDR_W-1:0] ret_addr;

  assign imem_addr = pc;
  assign halted    = (state == ST_HALTED);

`ifdef FETCH_RET_STACK_EN
  logic push;
  logic pop;
  logic stack_full;
  logic stack_empty;

  // A redirect always wins over a return, so a return that coincides with
  // a redirect never pops. A return on an empty stack does not redirect.
  assign push     = redirect_valid && call_valid;
  assign pop      = ret_valid && !redirect_valid;
  assign ret_take = pop && !stack_empty;

  fetch_ret_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_ret_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (ir_pc + ADDR_W'(1)),
    .pop_data  (ret_addr),
    .full      (stack_full),
    .empty     (stack_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stack_err <= 1'b0;
    end else if ((push && stack_full) || (pop && stack_empty)) begin
      stack_err <= 1'b1;
    end
  end
`else
  localparam int unused_stack_depth = STACK_DEPTH;
  logic unused_stack_inputs;

  assign unused_stack_inputs = call_valid ^ ret_valid;
  assign ret_take  = 1'b0;
  assign ret_addr  = '0;
  assign stack_err = 1'b0;
`endif

  // A new word is captured only while running, enabled, with the
  // instruction register free or being drained, and no control transfer.
  assign load = (state == ST_RUN) && fetch_en && (!ir_valid || ir_ready) &&
                !redirect_valid && !ret_take;

  // Control transfers discard the instruction register and restart fetch at
  // the new pc; the target word is then loaded on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      ir_valid <= 1'b0;
      ir_data  <= '0;
      ir_pc    <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_addr;
      ir_valid <= 1'b0;
      state    <= fetch_en ? ST_RUN : ST_IDLE;
    end else if (ret_take) begin
      pc       <= ret_addr;
      ir_valid <= 1'b0;
      state    <= fetch_en ? ST_RUN : ST_IDLE;
    end else begin
      if (load) begin
        ir_data  <= imem_data;
        ir_pc    <= pc;
        ir_valid <= 1'b1;
        pc       <= pc + ADDR_W'(1);
      end else if (ir_valid && ir_ready) begin
        ir_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (fetch_en) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (load && is_halt(imem_data[INSTR_W-1 -: 4])) begin
            state <= ST_HALTED;
          end else if (!fetch_en) begin
            state <= ST_IDLE;
          end
        end
        ST_HALTED: begin
          state <= ST_HALTED;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
